line_render_sched: RTL and testbench
====================================

# line_render_sched

Per-scanline render scheduler for the double-buffered linebuffer. It sequences the tile engine, then the sprite engine, then flips the display/draw buffer select once both have finished the next line. It detects lines that miss the swap point and applies frame-synchronous shadowing to the tilemap select. It sits between the VGA counters, the control register and the two draw engines, and replaces ad-hoc start/switch logic in the top level.

## Interface
Parameters:
- HTOTAL, 1600: hcount period in clk cycles.
- VACTIVE, 480: active lines.
- VTOTAL, 525: total lines per frame.
- TILE_H, 0: hcount value at which tile rendering of the next line starts.
- SWAP_H, 1590: hcount value at which the buffer flip is evaluated.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  synchronous, active-low reset.
- hcount  in  11  current horizontal count (0..HTOTAL-1).
- vcount  in  10  current line (0..VTOTAL-1).
- render_en  in  1  master enable, from the control register.
- tilemap_idx_in  in  2  tilemap select written by software.
- tile_done  in  1  level; high while the tile engine is idle.
- sprite_done  in  1  level; high while the sprite engine is idle.
- overrun_clr  in  1  one-cycle pulse that clears overrun_sticky.
- tile_start  out  1  one-cycle start pulse to the tile engine.
- sprite_start  out  1  one-cycle start pulse to the sprite engine.
- tilemap_idx  out  2  shadowed tilemap select driven to the tile engine.
- switch  out  1  linebuffer bank select.
- busy  out  1  high whenever the FSM is not IDLE.
- overrun_sticky  out  1  set when any line missed SWAP_H.
- overrun_cnt  out  16  count of missed lines (see Configuration).

## Operation
- Render line: vcount < VACTIVE-1 or vcount == VTOTAL-1. This renders line vcount+1, mod VTOTAL.
- FSM states: IDLE, TILE_ARM, TILE_WAIT, SPR_ARM, SPR_WAIT, READY, DRAIN.
- IDLE: on a render line, with hcount==TILE_START... specifically hcount==TILE_H and render_en=1: pulse tile_start, go to TILE_ARM.
- TILE_ARM (1 cycle, done ignored) -> TILE_WAIT.
- TILE_WAIT: on tile_done=1, pulse sprite_start and go to SPR_ARM.
- SPR_ARM (1 cycle) -> SPR_WAIT.
- SPR_WAIT: on sprite_done=1, go to READY.
- READY: at hcount==SWAP_H, toggle switch and go to IDLE.
- Overrun: hcount==SWAP_H while in TILE_ARM, TILE_WAIT, SPR_ARM or SPR_WAIT.
  - switch is not toggled.
  - overrun_sticky is set and overrun_cnt increments.
  - TILE_* states continue the sequence but enter DRAIN instead of READY once sprite_done=1.
  - SPR_* states go to DRAIN.
- DRAIN: wait for tile_done & sprite_done, then go to IDLE. No starts are issued and switch is never toggled from DRAIN.
- A TILE_H match that occurs outside IDLE is ignored; the next line is dropped. An overrun is recorded only at the SWAP_H check.
- tilemap_idx is loaded from tilemap_idx_in when vcount==VTOTAL-1 and hcount==TILE_H. This happens in the same cycle as the tile_start pulse for line 0, independent of FSM state. At all other times tilemap_idx holds its value.
- render_en=0: no new tile_start is issued. A sequence already in progress completes normally, including its swap. switch is held while in IDLE.

## Timing
- tile_start and sprite_start are registered single-cycle pulses. tile_start rises on the cycle after the hcount==TILE_H sample.
- Latency from tile_done high (sampled in TILE_WAIT) to sprite_start: 1 cycle.
- switch toggles on the clock edge after hcount==SWAP_H is sampled in READY.
- overrun_sticky set has priority over overrun_clr in the same cycle. The clear takes effect on the next cycle.
- overrun_cnt saturates at 16'hFFFF and is cleared only by reset.
- Reset values: state IDLE; tile_start 0, sprite_start 0, switch 0, tilemap_idx 0, busy 0, overrun_sticky 0, overrun_cnt 0.
- Reset mid-sequence returns to IDLE in one cycle. Engines are not aborted; the next sequence waits for IDLE and TILE_H.

## Configuration
- LINE_SCHED_OVERRUN_CNT_EN defined: the 16-bit saturating overrun_cnt register is implemented.
- Not defined: overrun_cnt is tied to 16'h0 and no counter register is built. overrun_sticky is unaffected.

## Test plan
- Reset: hold reset_n=0 for 5 cycles with render_en=1 -> all outputs 0 and busy=0 on release.
- Normal line: vcount=10; tile_done drops for 40 cycles after tile_start; sprite_done drops for 200 cycles after sprite_start -> tile_start at hcount 1, sprite_start 1 cycle after tile_done rises, switch toggles once, after hcount 1590.
- Overrun: sprite_done held low until hcount 1595 -> switch unchanged, overrun_sticky=1, overrun_cnt=1. FSM passes through DRAIN to IDLE, and the next line proceeds normally.
- Frame shadow: write tilemap_idx_in=2 at vcount 100 -> tilemap_idx stays 0 until vcount 524 / hcount 0, then becomes 2.
- Blanking and enable: vcount 479..523 -> no starts. Set render_en=0 mid-sequence -> the current line still swaps and no further tile_start is issued.
- Clear priority: overrun_clr asserted in the same cycle as a new overrun -> overrun_sticky stays 1. overrun_clr alone on a later cycle -> 0 the next cycle.

Source files
------------

// File: rtl/line_render_sched_if.sv
// Handshake bundle between the VGA counters/control register/draw engines and the line render scheduler.
interface line_render_sched_if;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        render_en;
  logic [1:0]  tilemap_idx_in;
  logic        tile_done;
  logic        sprite_done;
  logic        overrun_clr;
  logic        tile_start;
  logic        sprite_start;
  logic [1:0]  tilemap_idx;
  logic        switch;
  logic        busy;
  logic        overrun_sticky;
  logic [15:0] overrun_cnt;

  modport master (
    output hcount, vcount, render_en, tilemap_idx_in, tile_done, sprite_done, overrun_clr,
    input  tile_start, sprite_start, tilemap_idx, switch, busy, overrun_sticky, overrun_cnt
  );

  modport slave (
    input  hcount, vcount, render_en, tilemap_idx_in, tile_done, sprite_done, overrun_clr,
    output tile_start, sprite_start, tilemap_idx, switch, busy, overrun_sticky, overrun_cnt
  );
endinterface

// File: rtl/line_render_sched.sv
// Per-scanline scheduler: tile engine, then sprite engine, then linebuffer flip at SWAP_H.
// Define LINE_SCHED_OVERRUN_CNT_EN to build the 16-bit saturating missed-line counter.
module line_render_sched #(
  parameter int HTOTAL  = 1600,
  parameter int VACTIVE = 480,
  parameter int VTOTAL  = 525,
  parameter int TILE_H  = 0,
  parameter int SWAP_H  = 1590
) (
  input logic               clk,
  input logic               reset_n,
  line_render_sched_if.slave bus
);

  // Out-of-range match points are pulled onto the last cycle of the line so they still fire.
  localparam logic [10:0] TILE_HC = 11'((TILE_H < HTOTAL) ? TILE_H : HTOTAL - 1);
  localparam logic [10:0] SWAP_HC = 11'((SWAP_H < HTOTAL) ? SWAP_H : HTOTAL - 1);
  localparam logic [9:0]  VDRAW_END = 10'(VACTIVE - 1);
  localparam logic [9:0]  VLAST     = 10'(VTOTAL - 1);

  typedef enum logic [2:0] {
    IDLE, TILE_ARM, TILE_WAIT, SPR_ARM, SPR_WAIT, READY, DRAIN
  } state_t;

  state_t     state;
  logic       tile_start_r;
  logic       sprite_start_r;
  logic       bank_sel;
  logic       missed;
  logic       sticky;
  logic [1:0] tilemap_r;

  logic render_line;
  logic tile_hit;
  logic swap_hit;
  logic overrun;

  assign render_line = (bus.vcount < VDRAW_END) || (bus.vcount == VLAST);
  assign tile_hit    = (bus.hcount == TILE_HC);
  assign swap_hit    = (bus.hcount == SWAP_HC);
  assign overrun     = swap_hit && ((state == TILE_ARM) || (state == TILE_WAIT) ||
                                    (state == SPR_ARM)  || (state == SPR_WAIT));

  // A line that misses SWAP_H keeps running to completion but must never flip the bank.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      tile_start_r   <= 1'b0;
      sprite_start_r <= 1'b0;
      bank_sel       <= 1'b0;
      missed         <= 1'b0;
      sticky         <= 1'b0;
    end else begin
      tile_start_r   <= 1'b0;
      sprite_start_r <= 1'b0;

      if (overrun)
        sticky <= 1'b1;
      else if (bus.overrun_clr)
        sticky <= 1'b0;

      case (state)
        IDLE: begin
          missed <= 1'b0;
          if (tile_hit && render_line && bus.render_en) begin
            tile_start_r <= 1'b1;
            state        <= TILE_ARM;
          end
        end
        TILE_ARM: begin
          if (swap_hit) missed <= 1'b1;
          state <= TILE_WAIT;
        end
        TILE_WAIT: begin
          if (swap_hit) missed <= 1'b1;
          if (bus.tile_done) begin
            sprite_start_r <= 1'b1;
            state          <= SPR_ARM;
          end
        end
        SPR_ARM: begin
          state <= swap_hit ? DRAIN : SPR_WAIT;
        end
        SPR_WAIT: begin
          if (swap_hit || (bus.sprite_done && missed))
            state <= DRAIN;
          else if (bus.sprite_done)
            state <= READY;
        end
        READY: begin
          if (swap_hit) begin
            bank_sel <= ~bank_sel;
            state    <= IDLE;
          end
        end
        DRAIN: begin
          if (bus.tile_done && bus.sprite_done)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tilemap select is frame-synchronous: it only changes alongside the start of line 0.
  always_ff @(posedge clk) begin
    if (!reset_n)
      tilemap_r <= 2'd0;
    else if ((bus.vcount == VLAST) && tile_hit)
      tilemap_r <= bus.tilemap_idx_in;
  end

`ifdef LINE_SCHED_OVERRUN_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  logic [15:0] ov_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)
      ov_cnt <= 16'd0;
    else if (overrun)
      ov_cnt <= sat_inc(ov_cnt);
  end

  assign bus.overrun_cnt = ov_cnt;
`else
  assign bus.overrun_cnt = 16'h0;
`endif

  assign bus.tile_start     = tile_start_r;
  assign bus.sprite_start   = sprite_start_r;
  assign bus.tilemap_idx    = tilemap_r;
  assign bus.switch         = bank_sel;
  assign bus.busy           = (state != IDLE);
  assign bus.overrun_sticky = sticky;

endmodule

// File: tb/tb_line_render_sched.sv
// Directed bench for line_render_sched: bench-driven counters, engine models and an event scoreboard.
module tb_line_render_sched;

  localparam int TILE_H = 0;
  localparam int SWAP_H = 1590;
  localparam int HTOTAL = 1600;
`ifdef LINE_SCHED_OVERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam int K_TILE = 0;
  localparam int K_SPR  = 1;
  localparam int K_SW   = 2;

  typedef struct {
    int kind;
    int v;
    int h;
  } ev_t;

  logic clk;
  logic reset_n;
  line_render_sched_if bus ();

  line_render_sched #(
    .HTOTAL(HTOTAL), .VACTIVE(480), .VTOTAL(525), .TILE_H(TILE_H), .SWAP_H(SWAP_H)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int  checks = 0;
  int  failures = 0;
  ev_t q[$];

  bit  hold_rst = 1'b1;
  bit  in_rst = 1'b0;
  int  rst_h = -1;
  int  clr_h = -1;
  logic prev_sw = 1'b0;
  int  t_lat = 40, s_lat = 200;
  int  t_cnt = 0, s_cnt = 0;
  int  ov_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input int kind, input int v, input int h);
    ev_t e;
    checks++;
    assert (q.size() != 0) else begin
      failures++;
      $error("FAIL sb_unexpected observed kind=%0d v=%0d h=%0d expected no event", kind, v, h);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      assert (e.kind == kind && e.v == v && e.h == h) else begin
        failures++;
        $error("FAIL sb_event observed kind=%0d v=%0d h=%0d expected kind=%0d v=%0d h=%0d",
               kind, v, h, e.kind, e.v, e.h);
      end
    end
  endtask

  task automatic push_ev(input int kind, input int v, input int h);
    ev_t e;
    e.kind = kind; e.v = v; e.h = h;
    q.push_back(e);
  endtask

  // A fully scheduled line: start at TILE_H, sprite after tile latency, flip at SWAP_H.
  task automatic expect_line(input int v, input int t, input int s, input bit flips);
    t_lat = t;
    s_lat = s;
    push_ev(K_TILE, v, TILE_H);
    push_ev(K_SPR, v, TILE_H + 1 + t);
    if (flips) push_ev(K_SW, v, SWAP_H);
  endtask

  // Runs after each active edge: scoreboard the pulses/flips, then advance the engine models.
  task automatic observe(input int v, input int h);
    if (bus.tile_start === 1'b1) sb_pop(K_TILE, v, h);
    if (bus.sprite_start === 1'b1) sb_pop(K_SPR, v, h);
    if (in_rst) begin
      chk("switch_in_reset", {31'd0, bus.switch}, 32'd0);
      prev_sw = 1'b0;
    end else if (bus.switch !== prev_sw) begin
      sb_pop(K_SW, v, h);
      prev_sw = bus.switch;
    end
    if (bus.tile_start === 1'b1) begin
      t_cnt = t_lat;
      bus.tile_done = 1'b0;
    end else if (t_cnt > 0) begin
      t_cnt--;
      if (t_cnt == 0) bus.tile_done = 1'b1;
    end
    if (bus.sprite_start === 1'b1) begin
      s_cnt = s_lat;
      bus.sprite_done = 1'b0;
    end else if (s_cnt > 0) begin
      s_cnt--;
      if (s_cnt == 0) bus.sprite_done = 1'b1;
    end
  endtask

  task automatic step(input int v, input int h);
    bus.vcount = 10'(v);
    bus.hcount = 11'(h);
    bus.overrun_clr = (h == clr_h);
    reset_n = !(hold_rst || (h == rst_h));
    in_rst = !reset_n;
    @(posedge clk);
    #1;
    observe(v, h);
  endtask

  task automatic run_line(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) step(v, h);
  endtask

  task automatic chk_ov(input string tag);
    chk({tag, "_cnt"}, {16'd0, bus.overrun_cnt}, CNT_EN ? 32'(ov_n) : 32'd0);
  endtask

  initial begin
    bus.hcount = '0;
    bus.vcount = '0;
    bus.render_en = 1'b1;
    bus.tilemap_idx_in = 2'd0;
    bus.tile_done = 1'b1;
    bus.sprite_done = 1'b1;
    bus.overrun_clr = 1'b0;
    reset_n = 1'b0;

    // Reset held for 5 cycles with render_en high.
    hold_rst = 1'b1;
    for (int h = 0; h < 5; h++) step(10, h);
    hold_rst = 1'b0;
    chk("rst_tile_start", {31'd0, bus.tile_start}, 32'd0);
    chk("rst_sprite_start", {31'd0, bus.sprite_start}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_tilemap", {30'd0, bus.tilemap_idx}, 32'd0);
    chk("rst_sticky", {31'd0, bus.overrun_sticky}, 32'd0);
    chk_ov("rst");

    // Normal line.
    expect_line(10, 40, 200, 1'b1);
    run_line(10, 0, 99);
    chk("normal_busy_mid", {31'd0, bus.busy}, 32'd1);
    run_line(10, 100, HTOTAL - 1);
    chk("normal_switch", {31'd0, bus.switch}, 32'd1);
    chk("normal_busy_end", {31'd0, bus.busy}, 32'd0);
    chk("normal_sticky", {31'd0, bus.overrun_sticky}, 32'd0);

    // Sprite phase overruns SWAP_H: drain, no flip.
    expect_line(11, 40, 1553, 1'b0);
    ov_n++;
    run_line(11, 0, 1592);
    chk("ovr_spr_busy_drain", {31'd0, bus.busy}, 32'd1);
    chk("ovr_spr_sticky", {31'd0, bus.overrun_sticky}, 32'd1);
    chk_ov("ovr_spr");
    run_line(11, 1593, HTOTAL - 1);
    chk("ovr_spr_idle", {31'd0, bus.busy}, 32'd0);
    chk("ovr_spr_switch", {31'd0, bus.switch}, 32'd1);

    expect_line(12, 40, 200, 1'b1);
    run_line(12, 0, HTOTAL - 1);
    chk("recover_switch", {31'd0, bus.switch}, 32'd0);

    // Tile phase overruns; the sequence spills over and the following line is dropped.
    expect_line(13, 1595, 20, 1'b0);
    ov_n++;
    run_line(13, 0, HTOTAL - 1);
    chk("ovr_tile_sticky", {31'd0, bus.overrun_sticky}, 32'd1);
    chk_ov("ovr_tile");
    run_line(14, 0, 9);
    chk("dropped_busy", {31'd0, bus.busy}, 32'd1);
    run_line(14, 10, HTOTAL - 1);
    chk("dropped_idle", {31'd0, bus.busy}, 32'd0);
    chk("dropped_switch", {31'd0, bus.switch}, 32'd0);

    expect_line(15, 40, 200, 1'b1);
    run_line(15, 0, HTOTAL - 1);

    // Clear alone, then clear coinciding with a fresh overrun.
    expect_line(16, 40, 200, 1'b1);
    clr_h = 500;
    run_line(16, 0, 499);
    chk("clr_before", {31'd0, bus.overrun_sticky}, 32'd1);
    run_line(16, 500, 500);
    chk("clr_after", {31'd0, bus.overrun_sticky}, 32'd0);
    run_line(16, 501, HTOTAL - 1);
    expect_line(17, 40, 1553, 1'b0);
    ov_n++;
    clr_h = SWAP_H;
    run_line(17, 0, SWAP_H);
    chk("clr_vs_set_sticky", {31'd0, bus.overrun_sticky}, 32'd1);
    chk_ov("clr_vs_set");
    clr_h = -1;
    run_line(17, SWAP_H + 1, HTOTAL - 1);

    expect_line(18, 40, 200, 1'b1);
    run_line(18, 0, HTOTAL - 1);
    chk("pre_reset_switch", {31'd0, bus.switch}, 32'd1);

    // Reset in the middle of a sequence.
    t_lat = 40; s_lat = 200;
    push_ev(K_TILE, 19, TILE_H);
    push_ev(K_SPR, 19, TILE_H + 41);
    run_line(19, 0, 99);
    rst_h = 100;
    run_line(19, 100, 100);
    rst_h = -1;
    ov_n = 0;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_sticky", {31'd0, bus.overrun_sticky}, 32'd0);
    chk_ov("midrst");
    run_line(19, 101, HTOTAL - 1);
    chk("midrst_switch", {31'd0, bus.switch}, 32'd0);

    // render_en drops mid-sequence: this line still flips, the next never starts.
    expect_line(20, 40, 200, 1'b1);
    run_line(20, 0, 99);
    bus.render_en = 1'b0;
    run_line(20, 100, HTOTAL - 1);
    chk("en_off_switch", {31'd0, bus.switch}, 32'd1);
    run_line(21, 0, HTOTAL - 1);
    chk("en_off_busy", {31'd0, bus.busy}, 32'd0);
    bus.render_en = 1'b1;

    // Blanking lines never start.
    run_line(479, 0, HTOTAL - 1);
    run_line(500, 0, HTOTAL - 1);
    run_line(523, 0, HTOTAL - 1);
    chk("blank_busy", {31'd0, bus.busy}, 32'd0);
    chk("blank_switch", {31'd0, bus.switch}, 32'd1);

    // Tilemap select shadowed to the start of line 0.
    bus.tilemap_idx_in = 2'd2;
    expect_line(100, 40, 200, 1'b1);
    run_line(100, 0, HTOTAL - 1);
    chk("shadow_hold", {30'd0, bus.tilemap_idx}, 32'd0);
    expect_line(524, 40, 200, 1'b1);
    run_line(524, 0, 0);
    chk("shadow_load", {30'd0, bus.tilemap_idx}, 32'd2);
    run_line(524, 1, HTOTAL - 1);
    bus.tilemap_idx_in = 2'd1;
    expect_line(0, 40, 200, 1'b1);
    run_line(0, 0, HTOTAL - 1);
    chk("shadow_keep", {30'd0, bus.tilemap_idx}, 32'd2);
    chk("final_switch", {31'd0, bus.switch}, 32'd0);

    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
